sp_ram_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request port, per-byte write enables and a selectable read-during-write mode. After reset, and on a soft clear, an internal sequencer zeroes every word before it accepts requests. It is the generic successor to the fixed 64x8 scratch RAM and serves as the standard local buffer for datapath blocks.

---
 rtl/sp_ram_ctrl_if.sv | 25 ++
 rtl/sp_ram_ctrl.sv | 154 +++++++++++++++
 tb/tb_sp_ram_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_ctrl_if.sv
// Request/response bus of the single-port RAM controller.
// The requester drives the master side; the RAM is the slave side.
interface sp_ram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sp_ram_ctrl.sv
// Single-port synchronous RAM with byte enables, selectable read-during-write
// data and a sequencer that zeroes every word after reset or soft clear.
module sp_ram_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  sp_ram_ctrl_if.slave    bus,
  output logic            init_done
);

  localparam int                BE_W     = DATA_W / 8;
  localparam int                CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] resp_word;

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Out-of-range accesses always answer zero, whatever the write mode.
  function automatic logic [DATA_W-1:0] select_rsp(
    input logic              we,
    input logic              valid_addr,
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] merged_w
  );
    if (!valid_addr)              return '0;
    if (we && (RDW_MODE != 0))    return merged_w;
    return old_w;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign run           = (state_q == ST_RUN);
  assign bus.req_ready = run;
  assign init_done     = run;
  assign accept        = bus.req_valid && run;

  assign in_range    = ({1'b0, bus.req_addr} < DEPTH_L);
  assign clr_addr    = ADDR_W'(cnt_q);
  assign old_word    = in_range ? mem[bus.req_addr] : '0;
  assign merged_word = merge_bytes(old_word, bus.req_wdata, bus.req_be);
  assign resp_word   = select_rsp(bus.req_we, in_range, old_word, merged_word);

  // Stage p0: memory update and response capture at the accepting edge.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (accept && bus.req_we && in_range) begin
      mem[bus.req_addr] <= merged_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) data_p0 <= resp_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              vld_p1;
      logic [DATA_W-1:0] data_p1;

      // Stage p1: optional output register, one extra cycle of latency.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign bus.rsp_valid = vld_p1;
      assign bus.rsp_data  = data_p1;
    end else begin : g_no_out_reg
      assign bus.rsp_valid = vld_p0;
      assign bus.rsp_data  = data_p0;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed bench: instance A is the default 8-bit/64-word read-first RAM,
// instance B is 32-bit, 48 words, write-through, with the output register.
module tb_sp_ram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;
  logic init_done_a, init_done_b;

  always #5 clk = ~clk;

  sp_ram_ctrl_if #(.DATA_W(8),  .ADDR_W(6)) a_if ();
  sp_ram_ctrl_if #(.DATA_W(32), .ADDR_W(6)) b_if ();

  sp_ram_ctrl #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .RDW_MODE(0), .OUT_REG(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr_a), .bus(a_if), .init_done(init_done_a)
  );

  sp_ram_ctrl #(.DATA_W(32), .ADDR_W(6), .DEPTH(48), .RDW_MODE(1), .OUT_REG(1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .bus(b_if), .init_done(init_done_b)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic a_go(input logic we, input logic [5:0] addr, input logic [7:0] wd, input logic be);
    a_if.req_valid = 1'b1;
    a_if.req_we    = we;
    a_if.req_addr  = addr;
    a_if.req_wdata = wd;
    a_if.req_be    = be;
    @(posedge clk); #1;
    a_if.req_valid = 1'b0;
  endtask

  task automatic b_go(input logic we, input logic [5:0] addr, input logic [31:0] wd, input logic [3:0] be);
    b_if.req_valid = 1'b1;
    b_if.req_we    = we;
    b_if.req_addr  = addr;
    b_if.req_wdata = wd;
    b_if.req_be    = be;
    @(posedge clk); #1;
    b_if.req_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_a, pulses, bad, n;
    logic [7:0] acc;

    a_if.req_valid = 0; a_if.req_we = 0; a_if.req_addr = 0; a_if.req_wdata = 0; a_if.req_be = 0;
    b_if.req_valid = 0; b_if.req_we = 0; b_if.req_addr = 0; b_if.req_wdata = 0; b_if.req_be = 0;

    repeat (2) @(posedge clk);
    #1;
    check("a_rst_ready",     a_if.req_ready, 0);
    check("a_rst_init_done", init_done_a,    0);
    check("a_rst_rsp_valid", a_if.rsp_valid, 0);
    check("a_rst_rsp_data",  a_if.rsp_data,  0);
    check("b_rst_ready",     b_if.req_ready, 0);
    check("b_rst_rsp_valid", b_if.rsp_valid, 0);

    rst = 1'b0;
    low_a = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (!a_if.req_ready) low_a++;
      if (i == 47) check("b_clear_ready_47", b_if.req_ready, 0);
      if (i == 48) begin
        check("b_clear_ready_48", b_if.req_ready, 1);
        check("b_init_done_48",   init_done_b,    1);
      end
      if (i == 63) check("a_clear_ready_63", a_if.req_ready, 0);
      if (i == 64) begin
        check("a_clear_ready_64", a_if.req_ready, 1);
        check("a_init_done_64",   init_done_a,    1);
      end
    end
    check("a_clear_low_cycles", low_a, 63);

    a_go(0, 6'd0, 8'h00, 1'b0);
    check("a_rd0_valid", a_if.rsp_valid, 1);
    check("a_rd0_data",  a_if.rsp_data,  8'h00);
    a_go(0, 6'd31, 8'h00, 1'b0);
    check("a_rd31_data", a_if.rsp_data,  8'h00);
    a_go(0, 6'd63, 8'h00, 1'b0);
    check("a_rd63_data", a_if.rsp_data,  8'h00);

    a_go(1, 6'd5, 8'hA5, 1'b1);
    check("a_wr5_valid", a_if.rsp_valid, 1);
    check("a_wr5_old",   a_if.rsp_data,  8'h00);
    a_go(0, 6'd5, 8'h00, 1'b0);
    check("a_b2b_rd5_valid", a_if.rsp_valid, 1);
    check("a_b2b_rd5_data",  a_if.rsp_data,  8'hA5);
    tick();
    check("a_idle_valid", a_if.rsp_valid, 0);
    check("a_idle_hold",  a_if.rsp_data,  8'hA5);

    a_go(1, 6'd9, 8'h3C, 1'b1);
    a_go(1, 6'd9, 8'h7E, 1'b1);
    check("a_rdw_read_first", a_if.rsp_data, 8'h3C);
    a_go(0, 6'd9, 8'h00, 1'b0);
    check("a_rd9_data", a_if.rsp_data, 8'h7E);

    a_go(1, 6'd5, 8'hFF, 1'b0);
    check("a_be0_valid", a_if.rsp_valid, 1);
    check("a_be0_rsp",   a_if.rsp_data,  8'hA5);
    a_go(0, 6'd5, 8'h00, 1'b0);
    check("a_be0_unchanged", a_if.rsp_data, 8'hA5);

    for (int i = 0; i < 16; i++) a_go(1, 6'(i), 8'(i * 3 + 1), 1'b1);
    pulses = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      a_go(0, 6'(i), 8'h00, 1'b0);
      if (a_if.rsp_valid) pulses++;
      if (a_if.rsp_data !== 8'(i * 3 + 1)) bad++;
    end
    check("a_stream_pulses", pulses, 16);
    check("a_stream_bad",    bad,    0);

    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      clr_a = (k == 7);
      a_go(0, 6'(k), 8'h00, 1'b0);
      clr_a = 1'b0;
      if (a_if.rsp_valid) pulses++;
    end
    check("a_clr_last_rsp", a_if.rsp_data, 8'h16);
    a_if.req_valid = 1'b1;
    a_if.req_we    = 1'b0;
    a_if.req_addr  = 6'd8;
    n = 0;
    while (!a_if.req_ready && n < 200) begin
      n++;
      tick();
      if (a_if.rsp_valid) pulses++;
    end
    a_if.req_valid = 1'b0;
    check("a_clr_low_cycles", n,      64);
    check("a_clr_pulses",     pulses, 8);
    check("a_clr_init_done",  init_done_a, 1);

    pulses = 0; acc = 8'h00;
    for (int i = 0; i < 64; i++) begin
      a_go(0, 6'(i), 8'h00, 1'b0);
      if (a_if.rsp_valid) pulses++;
      acc = acc | a_if.rsp_data;
    end
    check("a_post_clr_pulses", pulses, 64);
    check("a_post_clr_or",     acc,    8'h00);

    b_go(1, 6'd3, 32'h11223344, 4'hF);
    check("b_latency_not_1", b_if.rsp_valid, 0);
    tick();
    check("b_wr_full_valid", b_if.rsp_valid, 1);
    check("b_wr_full_data",  b_if.rsp_data,  32'h11223344);
    b_go(1, 6'd3, 32'hAABBCCDD, 4'b0101);
    tick();
    check("b_wr_be_through", b_if.rsp_data, 32'h11BB33DD);
    b_go(0, 6'd3, 32'h0, 4'h0);
    tick();
    check("b_rd_merged", b_if.rsp_data, 32'h11BB33DD);

    b_go(1, 6'd5, 32'h000000A5, 4'h1);
    check("b_b2b_lat0", b_if.rsp_valid, 0);
    b_go(0, 6'd5, 32'h0, 4'h0);
    check("b_b2b_wr_valid", b_if.rsp_valid, 1);
    check("b_b2b_wr_data",  b_if.rsp_data,  32'h000000A5);
    tick();
    check("b_b2b_rd_valid", b_if.rsp_valid, 1);
    check("b_b2b_rd_data",  b_if.rsp_data,  32'h000000A5);
    tick();
    check("b_b2b_done", b_if.rsp_valid, 0);

    b_go(1, 6'd9, 32'h0000003C, 4'h1);
    tick();
    b_go(1, 6'd9, 32'h0000007E, 4'h1);
    tick();
    check("b_rdw_write_through", b_if.rsp_data, 32'h0000007E);

    b_go(1, 6'd2, 32'h12345678, 4'hF);
    tick();
    pulses = 0;
    b_go(1, 6'd50, 32'hFFFFFFFF, 4'hF);
    if (b_if.rsp_valid) pulses++;
    b_go(0, 6'd50, 32'h0, 4'h0);
    if (b_if.rsp_valid) pulses++;
    check("b_oor_wr_rsp", b_if.rsp_data, 32'h0);
    tick();
    if (b_if.rsp_valid) pulses++;
    check("b_oor_rd_rsp", b_if.rsp_data, 32'h0);
    tick();
    check("b_oor_pulses", pulses, 2);
    b_go(0, 6'd2, 32'h0, 4'h0);
    tick();
    check("b_oor_alias_kept", b_if.rsp_data, 32'h12345678);

    a_go(1, 6'd3, 8'h5A, 1'b1);
    a_if.req_valid = 1'b1; a_if.req_we = 1'b0; a_if.req_addr = 6'd3;
    b_if.req_valid = 1'b1; b_if.req_we = 1'b0; b_if.req_addr = 6'd3;
    tick();
    a_if.req_valid = 1'b0;
    b_if.req_valid = 1'b0;
    check("a_pre_rst_valid", a_if.rsp_valid, 1);
    check("a_pre_rst_data",  a_if.rsp_data,  8'h5A);
    rst = 1'b1;
    #1;
    check("a_midrst_valid", a_if.rsp_valid, 0);
    check("a_midrst_data",  a_if.rsp_data,  8'h00);
    check("a_midrst_ready", a_if.req_ready, 0);
    check("a_midrst_init",  init_done_a,    0);
    tick();
    check("b_midrst_valid", b_if.rsp_valid, 0);
    check("b_midrst_data",  b_if.rsp_data,  32'h0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
